divider_scheduler: RTL

//  Shares one sequential 8-bit divider (start pulse on its synchronous 'reset' input, result on 'ready') between

---
 rtl/divider_scheduler_pkg.sv | 8 +
 rtl/divider_scheduler_rr_arbiter.sv | 32 +++
 rtl/divider_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/divider_scheduler_pkg.sv
// Shared types and constants for the divider scheduler: FSM state encoding
// and the fixed quotient reported when a request divides by zero.
package divider_scheduler_pkg;
    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] DIV0_QUOTIENT = 8'hFF;

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
endpackage

// File: rtl/divider_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after the
// pointer (wrapping) and returns it both one-hot and as an index.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);
    logic [IDW-1:0] w_rot [NREQ];

    // w_rot[k] is the requester index examined k-th in this cycle's priority order
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        assign w_rot[gi] = IDW'((int'(i_ptr) + gi) % NREQ);
    end

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!o_any && i_req[w_rot[k]]) begin
                o_any            = 1'b1;
                o_idx            = w_rot[k];
                o_grant[w_rot[k]] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/divider_scheduler.sv
// Shares one sequential 8-bit divider between NREQ requesters: round-robin grant,
// divider start/capture with timeout, held response until the consumer accepts.
module divider_scheduler
    import divider_scheduler_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = 15,
    localparam int IDW     = $clog2(NREQ),
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [8*NREQ-1:0]    req_numerator,
    input  logic [8*NREQ-1:0]    req_denominator,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [DATA_W-1:0]    resp_quotient,
    output logic [DATA_W-1:0]    resp_remainder,
    output logic                 resp_div0,
    output logic                 resp_timeout,
    output logic                 busy,
    output logic                 div_start,
    output logic [DATA_W-1:0]    div_numerator,
    output logic [DATA_W-1:0]    div_denominator,
    input  logic [DATA_W-1:0]    div_quotient,
    input  logic [DATA_W-1:0]    div_remainder,
    input  logic                 div_ready
);
    state_t              r_state, w_state_next;
    logic [IDW-1:0]      r_ptr, w_ptr_next;
    logic [IDW-1:0]      r_id, w_id_next;
    logic [DATA_W-1:0]   r_num, w_num_next;
    logic [DATA_W-1:0]   r_den, w_den_next;
    logic [DATA_W-1:0]   r_q, w_q_next;
    logic [DATA_W-1:0]   r_r, w_r_next;
    logic                r_div0, w_div0_next;
    logic                r_tmo, w_tmo_next;
    logic [CW-1:0]       r_cnt, w_cnt_next;

    logic [DATA_W-1:0]   w_req_num [NREQ];
    logic [DATA_W-1:0]   w_req_den [NREQ];
    logic [NREQ-1:0]     w_grant;
    logic [IDW-1:0]      w_gidx;
    logic                w_any;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_req_num[gi] = req_numerator[8*gi +: 8];
        assign w_req_den[gi] = req_denominator[8*gi +: 8];
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_num   <= '0;
            r_den   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_div0  <= 1'b0;
            r_tmo   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_id    <= w_id_next;
            r_num   <= w_num_next;
            r_den   <= w_den_next;
            r_q     <= w_q_next;
            r_r     <= w_r_next;
            r_div0  <= w_div0_next;
            r_tmo   <= w_tmo_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_id_next    = r_id;
        w_num_next   = r_num;
        w_den_next   = r_den;
        w_q_next     = r_q;
        w_r_next     = r_r;
        w_div0_next  = r_div0;
        w_tmo_next   = r_tmo;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_id_next   = w_gidx;
                    w_ptr_next  = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
                    w_num_next  = w_req_num[w_gidx];
                    w_den_next  = w_req_den[w_gidx];
                    w_cnt_next  = '0;
                    w_tmo_next  = 1'b0;
                    // A zero divisor never reaches the divider; answer straight away
                    if (w_req_den[w_gidx] == '0) begin
                        w_q_next     = DIV0_QUOTIENT;
                        w_r_next     = w_req_num[w_gidx];
                        w_div0_next  = 1'b1;
                        w_state_next = RESP;
                    end else begin
                        w_div0_next  = 1'b0;
                        w_state_next = START;
                    end
                end
            end
            START: w_state_next = WAIT;
            WAIT: begin
                if (div_ready) begin
                    w_q_next     = div_quotient;
                    w_r_next     = div_remainder;
                    w_state_next = RESP;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_q_next     = '0;
                    w_r_next     = '0;
                    w_tmo_next   = 1'b1;
                    w_state_next = RESP;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_div0_next  = 1'b0;
                    w_tmo_next   = 1'b0;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign req_ready       = (r_state == IDLE) ? w_grant : '0;
    assign busy            = (r_state != IDLE);
    assign resp_valid      = (r_state == RESP);
    assign div_start       = (r_state == START);
    assign div_numerator   = div_start ? r_num : '0;
    assign div_denominator = div_start ? r_den : '0;
    assign resp_id         = r_id;
    assign resp_quotient   = r_q;
    assign resp_remainder  = r_r;
    assign resp_div0       = r_div0;
    assign resp_timeout    = r_tmo;
endmodule
